// File: rtl/mc_datapath.sv
// Multicycle MIPS-subset core: one shared ALU, register file and memories,
// sequenced by a seven-state FSM with a program-load port and debug read port.
module mc_datapath #(
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int CNT_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          prog_we,
  input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
  input  logic [31:0]                   prog_data,
  input  logic [4:0]                    dbg_ra,
  output logic [31:0]                   dbg_rd,
  output logic                          busy,
  output logic                          halted,
  output logic                          err,
  output logic [31:0]                   pc_o,
  output logic [CNT_W-1:0]              retired
);

  localparam int IA = $clog2(IMEM_DEPTH);
  localparam int DA = $clog2(DMEM_DEPTH);

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_HALT = 6'h3F;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       pc_q, pc_d, ir_q, ir_d, a_q, a_d, b_q, b_d;
  logic [31:0]       tgt_q, tgt_d, alu_q, alu_d, mdr_q, mdr_d;
  logic              err_q, err_d, busy_q, busy_d, halted_q, halted_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [31:0]       rf_q [32];
  logic [31:0]       imem_q [IMEM_DEPTH];
  logic [31:0]       dmem_q [DMEM_DEPTH];

  logic              rf_we, dm_we, funct_ok;
  logic [4:0]        rf_wa;
  logic [31:0]       rf_wd, alu_res, imm_sext;
  logic [5:0]        op, funct;
  logic [4:0]        rs, rt, rd;
  logic [DA-1:0]     dm_idx;

  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};
  assign dm_idx   = alu_q[DA+1:2];
  assign funct_ok = funct inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};

  // Non-R opcodes only ever need A + sign-extended immediate.
  always_comb begin
    alu_res = a_q + imm_sext;
    if (op == OP_R) begin
      case (funct)
        FN_SUB:  alu_res = a_q - b_q;
        FN_AND:  alu_res = a_q & b_q;
        FN_OR:   alu_res = a_q | b_q;
        FN_SLT:  alu_res = {31'd0, $signed(a_q) < $signed(b_q)};
        default: alu_res = a_q + b_q;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    tgt_d     = tgt_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    err_d     = err_q;
    retired_d = retired_q;
    rf_we     = 1'b0;
    rf_wa     = 5'd0;
    rf_wd     = 32'd0;
    dm_we     = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d   = S_FETCH;
          pc_d      = 32'd0;
          retired_d = '0;
          err_d     = 1'b0;
        end
      end
      S_FETCH: begin
        if (pc_q >= 32'(4 * IMEM_DEPTH)) begin
          err_d   = 1'b1;
          state_d = S_HALT;
        end else begin
          ir_d    = imem_q[pc_q[IA+1:2]];
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d   = rf_q[rs];
        b_d   = rf_q[rt];
        tgt_d = pc_q + {imm_sext[29:0], 2'b00};
        case (op)
          OP_J: begin
            pc_d      = {pc_q[31:28], ir_q[25:0], 2'b00};
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
          OP_HALT: begin
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_HALT;
          end
          OP_R: begin
            if (funct_ok) state_d = S_EXEC;
            else begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end
          end
          OP_ADDI, OP_LW, OP_SW, OP_BEQ: state_d = S_EXEC;
          default: begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_EXEC: begin
        alu_d = alu_res;
        case (op)
          OP_BEQ: begin
            if (a_q == b_q) pc_d = tgt_q;
            retired_d = retired_q + CNT_W'(1);
            state_d   = S_FETCH;
          end
          OP_LW, OP_SW: begin
            if (alu_res[1:0] != 2'b00) begin
              err_d   = 1'b1;
              state_d = S_HALT;
            end else begin
              state_d = S_MEM;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          dm_we     = 1'b1;
          retired_d = retired_q + CNT_W'(1);
          state_d   = S_FETCH;
        end else begin
          mdr_d   = dmem_q[dm_idx];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_wa     = (op == OP_R) ? rd : rt;
        rf_wd     = (op == OP_LW) ? mdr_q : alu_q;
        rf_we     = (rf_wa != 5'd0);
        retired_d = retired_q + CNT_W'(1);
        state_d   = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d   = !(state_d inside {S_IDLE, S_HALT});
  assign halted_d = (state_d == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= 32'd0;
      ir_q      <= 32'd0;
      a_q       <= 32'd0;
      b_q       <= 32'd0;
      tgt_q     <= 32'd0;
      alu_q     <= 32'd0;
      mdr_q     <= 32'd0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      tgt_q     <= tgt_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
      if (rf_we) rf_q[rf_wa] <= rf_wd;
    end
  end

  // Memories are not reset; program loads are locked out while running.
  always_ff @(posedge clk) begin
    if (prog_we && !busy_q) imem_q[prog_addr] <= prog_data;
    if (dm_we) dmem_q[dm_idx] <= b_q;
  end

  assign dbg_rd  = (dbg_ra == 5'd0) ? 32'd0 : rf_q[dbg_ra];
  assign busy    = busy_q;
  assign halted  = halted_q;
  assign err     = err_q;
  assign pc_o    = pc_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: directed vector table, corner sequences and random
// programs checked against an instruction-level reference interpreter.
module tb_mc_datapath;
  localparam int IMD = 32;
  localparam int DMD = 8;
  localparam int CW  = 32;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic          clk, rst_n, start, prog_we;
  logic [4:0]    prog_addr;
  logic [31:0]   prog_data, dbg_rd, pc_o;
  logic [4:0]    dbg_ra;
  logic          busy, halted, err;
  logic [CW-1:0] retired;

  mc_datapath #(.IMEM_DEPTH(IMD), .DMEM_DEPTH(DMD), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .dbg_ra(dbg_ra),
    .dbg_rd(dbg_rd), .busy(busy), .halted(halted), .err(err),
    .pc_o(pc_o), .retired(retired)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: expected PC at each FETCH and the cycle it happens in
  logic [31:0] exp_q[$];
  int          exp_t[$];

  // reference machine state
  logic [31:0] m_imem [IMD];
  logic [31:0] m_rf   [32];
  logic [31:0] m_dmem [DMD];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] j_ins(input logic [25:0] tg);
    return {6'h02, tg};
  endfunction

  // Instruction-level interpreter; cycle counts are busy cycles per instruction.
  task automatic model_run(output int cyc, output logic e, output int ret);
    logic [31:0] pc, ir, a, b, imm, addr, v;
    logic [4:0]  rs, rt, rd;
    logic        done;
    pc = 0; cyc = 0; e = 0; ret = 0; done = 0;
    exp_q.delete(); exp_t.delete();
    for (int s = 0; s < 500 && !done; s++) begin
      if (pc >= 4 * IMD) begin
        e = 1; cyc += 1; done = 1;
      end else begin
        exp_t.push_back(cyc); exp_q.push_back(pc);
        ir = m_imem[int'(pc >> 2)]; pc = pc + 4;
        rs = ir[25:21]; rt = ir[20:16]; rd = ir[15:11];
        imm = {{16{ir[15]}}, ir[15:0]};
        a = m_rf[rs]; b = m_rf[rt]; v = 0;
        case (ir[31:26])
          6'h00: begin
            case (ir[5:0])
              6'h20: v = a + b;
              6'h22: v = a - b;
              6'h24: v = a & b;
              6'h25: v = a | b;
              6'h2A: v = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
              default: begin e = 1; done = 1; end
            endcase
            if (done) cyc += 2;
            else begin
              if (rd != 0) m_rf[rd] = v;
              cyc += 4; ret++;
            end
          end
          6'h08: begin
            if (rt != 0) m_rf[rt] = a + imm;
            cyc += 4; ret++;
          end
          6'h23, 6'h2B: begin
            addr = a + imm;
            if (addr[1:0] != 0) begin
              e = 1; done = 1; cyc += 3;
            end else if (ir[31:26] == 6'h23) begin
              if (rt != 0) m_rf[rt] = m_dmem[int'((addr >> 2) % DMD)];
              cyc += 5; ret++;
            end else begin
              m_dmem[int'((addr >> 2) % DMD)] = b;
              cyc += 4; ret++;
            end
          end
          6'h04: begin
            if (a == b) pc = pc + (imm << 2);
            cyc += 3; ret++;
          end
          6'h02: begin
            pc = {pc[31:28], ir[25:0], 2'b00};
            cyc += 2; ret++;
          end
          6'h3F: begin
            cyc += 2; ret++; done = 1;
          end
          default: begin
            e = 1; done = 1; cyc += 2;
          end
        endcase
      end
    end
  endtask

  // driver tasks
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
  endtask

  task automatic load_prog(input logic [31:0] p[$]);
    foreach (p[i]) begin
      @(negedge clk);
      prog_we = 1'b1; prog_addr = 5'(i); prog_data = p[i];
      m_imem[i] = p[i];
    end
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
    dbg_ra = r;
    #1;
    v = dbg_rd;
  endtask

  // Start (optionally writing one word in the same cycle), follow the run
  // against the model's fetch schedule, then compare the final state.
  task automatic run_prog(input bit wr_en, input int wr_addr, input logic [31:0] wr_data,
                          input bit poke, output int t_halt);
    int cyc, ret, t;
    logic e;
    logic [31:0] v;
    if (wr_en) m_imem[wr_addr] = wr_data;
    model_run(cyc, e, ret);
    @(negedge clk);
    start = 1'b1; prog_we = wr_en; prog_addr = 5'(wr_addr); prog_data = wr_data;
    @(negedge clk);
    start = 1'b0; prog_we = 1'b0;
    t = 0;
    while (!halted && t < cyc + 40) begin
      if (t == 0) check("busy_at_start", {31'd0, busy}, 32'd1);
      if (poke && t == 1) begin
        prog_we = 1'b1; prog_addr = 5'd1; prog_data = i_ins(6'h08, 5'd7, 5'd0, 16'h0123);
      end
      if (poke && t == 2) prog_we = 1'b0;
      if (exp_t.size() > 0 && exp_t[0] == t) begin
        void'(exp_t.pop_front());
        check("pc_at_fetch", pc_o, exp_q.pop_front());
      end
      @(negedge clk);
      t++;
    end
    prog_we = 1'b0;
    check("halted", {31'd0, halted}, 32'd1);
    check("busy_cycles", t, cyc);
    check("busy_after_halt", {31'd0, busy}, 32'd0);
    check("err", {31'd0, err}, {31'd0, e});
    check("retired", retired, ret);
    for (int r = 0; r < 8; r++) begin
      read_reg(5'(r), v);
      check($sformatf("reg%0d", r), v, m_rf[r]);
    end
    t_halt = t;
  endtask

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [31:0] p[$];
    logic [31:0] v;
    int t;

    vecs[0] = '{"add",     r_ins(6'h20, 5'd3, 5'd1, 5'd2), 16'd5,     16'd7,     32'd12};
    vecs[1] = '{"sub",     r_ins(6'h22, 5'd3, 5'd1, 5'd2), 16'd5,     16'd7,     32'hFFFF_FFFE};
    vecs[2] = '{"and",     r_ins(6'h24, 5'd3, 5'd1, 5'd2), 16'h00F0,  16'h0FF0,  32'h0000_00F0};
    vecs[3] = '{"or_sext", r_ins(6'h25, 5'd3, 5'd1, 5'd2), 16'h8000,  16'h0001,  32'hFFFF_8001};
    vecs[4] = '{"slt_neg", r_ins(6'h2A, 5'd3, 5'd1, 5'd2), 16'hFFFF,  16'h0001,  32'd1};
    vecs[5] = '{"slt_pos", r_ins(6'h2A, 5'd3, 5'd1, 5'd2), 16'h0001,  16'hFFFF,  32'd0};
    vecs[6] = '{"sub_big", r_ins(6'h22, 5'd3, 5'd1, 5'd2), 16'h8000,  16'h7FFF,  32'hFFFF_0001};
    vecs[7] = '{"addi_m1", i_ins(6'h08, 5'd3, 5'd1, 16'hFFFF), 16'h0000, 16'h0000, 32'hFFFF_FFFF};

    start = 0; prog_we = 0; prog_addr = 0; prog_data = 0; dbg_ra = 0; rst_n = 1'b0;
    do_reset();

    // reset state
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_pc", pc_o, 32'd0);
    check("rst_retired", retired, 32'd0);
    read_reg(5'd5, v);
    check("rst_reg5", v, 32'd0);

    // fill imem with halts and clear data memory
    p.delete();
    for (int i = 0; i < IMD; i++) p.push_back(HALT_W);
    load_prog(p);
    p.delete();
    for (int i = 0; i < DMD; i++) p.push_back(i_ins(6'h2B, 5'd0, 5'd0, 16'(4 * i)));
    p.push_back(HALT_W);
    load_prog(p);
    run_prog(0, 0, 0, 0, t);

    // ALU vector table
    for (int k = 0; k < 8; k++) begin
      p = '{i_ins(6'h08, 5'd1, 5'd0, vecs[k].a), i_ins(6'h08, 5'd2, 5'd0, vecs[k].b),
            vecs[k].instr, HALT_W};
      load_prog(p);
      run_prog(0, 0, 0, 0, t);
      read_reg(5'd3, v);
      check({"vec_", vecs[k].name}, v, vecs[k].exp);
    end

    // basic program: halted 15 cycles after start
    p = '{i_ins(6'h08, 5'd1, 5'd0, 16'd5), i_ins(6'h08, 5'd2, 5'd0, 16'd7),
          r_ins(6'h20, 5'd3, 5'd1, 5'd2), HALT_W};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    check("basic_latency", t + 1, 32'd15);
    read_reg(5'd3, v);
    check("basic_r3", v, 32'd12);
    check("basic_retired", retired, 32'd4);
    check("basic_err", {31'd0, err}, 32'd0);

    // store / load
    p = '{i_ins(6'h08, 5'd1, 5'd0, 16'h55), i_ins(6'h2B, 5'd1, 5'd0, 16'd8),
          i_ins(6'h23, 5'd2, 5'd0, 16'd8), HALT_W};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    check("ldst_latency", t + 1, 32'd16);
    read_reg(5'd2, v);
    check("ldst_r2", v, 32'h55);

    // branches taken / not taken, write to $0 discarded
    p = '{i_ins(6'h04, 5'd0, 5'd0, 16'd1), i_ins(6'h08, 5'd4, 5'd0, 16'd1),
          i_ins(6'h08, 5'd5, 5'd0, 16'd2), i_ins(6'h04, 5'd0, 5'd5, 16'd1),
          i_ins(6'h08, 5'd6, 5'd0, 16'd3), i_ins(6'h08, 5'd0, 5'd0, 16'd9), HALT_W};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    read_reg(5'd4, v);
    check("beq_skip_r4", v, 32'd0);
    read_reg(5'd5, v);
    check("beq_r5", v, 32'd2);
    read_reg(5'd6, v);
    check("beq_fall_r6", v, 32'd3);
    read_reg(5'd0, v);
    check("r0_zero", v, 32'd0);
    check("beq_retired", retired, 32'd6);

    // error paths
    p = '{i_ins(6'h08, 5'd7, 5'd0, 16'd1), 32'hF800_0000};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    check("badop_err", {31'd0, err}, 32'd1);
    check("badop_retired", retired, 32'd1);
    p = '{i_ins(6'h08, 5'd7, 5'd0, 16'd1), i_ins(6'h23, 5'd2, 5'd0, 16'd3)};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    check("misalign_err", {31'd0, err}, 32'd1);
    check("misalign_retired", retired, 32'd1);
    p = '{i_ins(6'h08, 5'd7, 5'd0, 16'd1), j_ins(26'(IMD))};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    check("jump_oob_err", {31'd0, err}, 32'd1);
    check("jump_oob_retired", retired, 32'd2);

    // reset in the MEM cycle of a store
    p = '{i_ins(6'h08, 5'd1, 5'd0, 16'h66), i_ins(6'h2B, 5'd1, 5'd0, 16'd16), HALT_W};
    load_prog(p);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    check("sw_mem_pc", pc_o, 32'd8);
    rst_n = 1'b0;
    #2;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_halted", {31'd0, halted}, 32'd0);
    check("midrst_pc", pc_o, 32'd0);
    check("midrst_retired", retired, 32'd0);
    read_reg(5'd1, v);
    check("midrst_r1", v, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 32; r++) m_rf[r] = 32'd0;
    p = '{i_ins(6'h23, 5'd2, 5'd0, 16'd16), HALT_W};
    load_prog(p);
    run_prog(0, 0, 0, 0, t);
    read_reg(5'd2, v);
    check("sw_aborted", v, 32'd0);

    // back-to-back runs, locked-out write while busy, write together with start
    p = '{i_ins(6'h08, 5'd1, 5'd1, 16'd1), HALT_W};
    load_prog(p);
    run_prog(0, 0, 0, 1, t);
    run_prog(0, 0, 0, 0, t);
    read_reg(5'd1, v);
    check("b2b_r1", v, 32'd2);
    run_prog(1, 0, i_ins(6'h08, 5'd1, 5'd1, 16'd2), 0, t);
    read_reg(5'd1, v);
    check("wr_start_r1", v, 32'd4);
    check("wr_start_retired", retired, 32'd2);

    // random programs
    for (int k = 0; k < 30; k++) begin
      int n;
      logic [31:0] w;
      p.delete();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        logic [4:0] ra, rb, rc;
        ra = 5'($urandom_range(0, 7));
        rb = 5'($urandom_range(0, 7));
        rc = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 9))
          0, 1: begin
            case ($urandom_range(0, 4))
              0: w = r_ins(6'h20, rc, ra, rb);
              1: w = r_ins(6'h22, rc, ra, rb);
              2: w = r_ins(6'h24, rc, ra, rb);
              3: w = r_ins(6'h25, rc, ra, rb);
              default: w = r_ins(6'h2A, rc, ra, rb);
            endcase
          end
          2, 3, 4: w = i_ins(6'h08, rc, ra, 16'($urandom));
          5, 6: w = i_ins(6'h2B, rb, 5'd0, 16'(4 * $urandom_range(0, 15)));
          7: w = i_ins(6'h23, rc, 5'd0, 16'(4 * $urandom_range(0, 15) +
                                             (($urandom_range(0, 15) == 0) ? 1 : 0)));
          default: w = i_ins(6'h04, rb, ra, 16'($urandom_range(0, 2)));
        endcase
        p.push_back(w);
      end
      p.push_back(HALT_W);
      load_prog(p);
      run_prog(0, 0, 0, 0, t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "timeout");
  end

endmodule
